input_log_uploader: RTL and testbench



---
 rtl/input_log_uploader.sv | 166 ++++++++++++++++
 tb/tb_input_log_uploader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_log_uploader.sv
// Joystick change logger: timestamps joystick_0 changes with a frame count and serves the log over ioctl upload.
// Optional: define INPUT_LOG_ANALOG_EN to also log joystick_analog_0 in the record pad field.
module input_log_uploader #(
  parameter int          AW              = 10,
  parameter logic [7:0]  INDEX           = 8'd2,
  parameter bit          CLEAR_ON_UPLOAD = 1'b1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          vs,
  input  logic [31:0]   joystick_0,
  input  logic [15:0]   joystick_analog_0,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          overflow,
  output logic [AW:0]   count,
  output logic [1:0]    rd_state
);

  localparam int         DEPTH   = 1 << AW;
  localparam logic [15:0] DEPTH16 = (AW >= 16) ? 16'hFFFF : 16'(DEPTH);

  // Read handshake: ioctl_rd is accepted only in S_IDLE while selected; ioctl_wait stays
  // high until ioctl_din holds the requested byte, and the HPS must not strobe again before then.
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LATCH} state_t;
  state_t state_q, state_d;

  logic        sel, sel_q, sel_fall, vs_q;
  logic [15:0] frame;
  logic [31:0] last_joy;
  logic [15:0] pad;
  logic        changed, push, clr, analog_flag;
  logic [24:0] addr_q;
  logic [63:0] rd_word;
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] rec_idx;
  logic [15:0] cnt16;
  logic [31:0] limit;
  logic        out_of_range;
  logic [7:0]  byte_sel;

  assign sel      = ioctl_upload && (ioctl_index == INDEX);
  assign sel_fall = sel_q && !sel;
  assign clr      = sel_fall && CLEAR_ON_UPLOAD;
  // count[AW] set means the log holds exactly DEPTH records.
  assign push     = !sel && changed && !count[AW];
  assign rd_state = state_q;

`ifdef INPUT_LOG_ANALOG_EN
  logic [15:0] last_ana;
  assign pad         = joystick_analog_0;
  assign changed     = (joystick_0 != last_joy) || (joystick_analog_0 != last_ana);
  assign analog_flag = 1'b1;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)  last_ana <= 16'h0;
    else if (clr)  last_ana <= 16'h0;
    else if (push) last_ana <= joystick_analog_0;
  end
`else
  logic unused_analog;
  assign unused_analog = ^joystick_analog_0;
  assign pad           = 16'h0;
  assign changed       = (joystick_0 != last_joy);
  assign analog_flag   = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vs_q     <= 1'b0;
      sel_q    <= 1'b0;
      frame    <= 16'h0;
      count    <= '0;
      overflow <= 1'b0;
      last_joy <= 32'h0;
    end else begin
      vs_q  <= vs;
      sel_q <= sel;
      if (vs && !vs_q) frame <= frame + 16'd1;
      if (clr) begin
        count    <= '0;
        overflow <= 1'b0;
        last_joy <= 32'h0;
      end else if (push) begin
        count    <= count + (AW+1)'(1);
        last_joy <= joystick_0;
      end else if (!sel && changed && count[AW]) begin
        overflow <= 1'b1;
      end
    end
  end

  // Record layout in RAM: {frame, joystick, pad}; frame is the pre-increment value.
  always_ff @(posedge clk_sys) begin
    if (push) mem[count[AW-1:0]] <= {frame, joystick_0, pad};
    if (state_q == S_FETCH) rd_word <= mem[rec_idx];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ioctl_rd && sel) state_d = S_FETCH;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (sel_fall) state_d = S_IDLE;
  end

  assign rec_idx      = addr_q[AW+2:3] - AW'(1);
  assign cnt16        = 16'(count);
  assign limit        = (32'(count) << 3) + 32'd8;
  assign out_of_range = ({7'b0, addr_q} >= limit) || ((addr_q >> (AW+3)) != 25'd0);

  always_comb begin
    byte_sel = 8'hFF;
    if (!out_of_range) begin
      if (addr_q < 25'd8) begin
        case (addr_q[2:0])
          3'd0:    byte_sel = cnt16[7:0];
          3'd1:    byte_sel = cnt16[15:8];
          3'd2:    byte_sel = {6'b0, analog_flag, overflow};
          3'd4:    byte_sel = DEPTH16[7:0];
          3'd5:    byte_sel = DEPTH16[15:8];
          default: byte_sel = 8'h00;
        endcase
      end else begin
        case (addr_q[2:0])
          3'd0:    byte_sel = rd_word[55:48];
          3'd1:    byte_sel = rd_word[63:56];
          3'd2:    byte_sel = rd_word[23:16];
          3'd3:    byte_sel = rd_word[31:24];
          3'd4:    byte_sel = rd_word[39:32];
          3'd5:    byte_sel = rd_word[47:40];
          3'd6:    byte_sel = rd_word[7:0];
          default: byte_sel = rd_word[15:8];
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 25'd0;
      ioctl_din  <= 8'h0;
      ioctl_wait <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && ioctl_rd && sel) begin
        addr_q     <= ioctl_addr;
        ioctl_wait <= 1'b1;
      end
      if (state_q == S_LATCH && !sel_fall) begin
        ioctl_din  <= byte_sel;
        ioctl_wait <= 1'b0;
      end
      if (sel_fall) ioctl_wait <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_log_uploader.sv
// Bench for input_log_uploader: a default (AW=10) and a small (AW=2) instance share stimulus
// and are checked against a queue-based log model.
module tb_input_log_uploader;

  localparam bit ANALOG =
`ifdef INPUT_LOG_ANALOG_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        vs = 1'b0;
  logic [31:0] joystick_0 = 32'h0;
  logic [15:0] joystick_analog_0 = 16'h0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;

  logic [7:0]  ioctl_din, din_s;
  logic        ioctl_wait, wait_s, overflow, ovf_s;
  logic [10:0] count;
  logic [2:0]  count_s;
  logic [1:0]  rd_state, rd_state_s;

  int checks = 0;
  int errors = 0;

  input_log_uploader u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .vs(vs), .joystick_0(joystick_0),
    .joystick_analog_0(joystick_analog_0), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .overflow(overflow),
    .count(count), .rd_state(rd_state)
  );

  input_log_uploader #(.AW(2)) u_small (
    .clk_sys(clk_sys), .reset_n(reset_n), .vs(vs), .joystick_0(joystick_0),
    .joystick_analog_0(joystick_analog_0), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(din_s), .ioctl_wait(wait_s), .overflow(ovf_s),
    .count(count_s), .rd_state(rd_state_s)
  );

  // Clock / watchdog
  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: each log is a queue of {pad, joy, frame} in little-endian byte order.
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [31:0] m_last_joy [2];
  logic [15:0] m_last_ana [2];
  logic        m_ovf [2];
  logic [15:0] m_frame;
  logic        m_vs_prev, m_sel_prev, m_sel, m_chg;

  function automatic int log_size(int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic int log_depth(int k);
    return (k == 0) ? 1024 : 4;
  endfunction

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      exp_q0.delete();
      exp_q1.delete();
      for (int k = 0; k < 2; k++) begin
        m_last_joy[k] = 32'h0; m_last_ana[k] = 16'h0; m_ovf[k] = 1'b0;
      end
      m_frame = 16'h0; m_vs_prev = 1'b0; m_sel_prev = 1'b0;
    end else begin
      m_sel = ioctl_upload && (ioctl_index == 8'd2);
      for (int k = 0; k < 2; k++) begin
        m_chg = (joystick_0 != m_last_joy[k]) || (ANALOG && (joystick_analog_0 != m_last_ana[k]));
        if (!m_sel && m_chg) begin
          if (log_size(k) == log_depth(k)) m_ovf[k] = 1'b1;
          else begin
            if (k == 0) exp_q0.push_back({ANALOG ? joystick_analog_0 : 16'h0, joystick_0, m_frame});
            else        exp_q1.push_back({ANALOG ? joystick_analog_0 : 16'h0, joystick_0, m_frame});
            m_last_joy[k] = joystick_0;
            m_last_ana[k] = joystick_analog_0;
          end
        end
      end
      if (m_sel_prev && !m_sel) begin
        exp_q0.delete();
        exp_q1.delete();
        for (int k = 0; k < 2; k++) begin
          m_last_joy[k] = 32'h0; m_last_ana[k] = 16'h0; m_ovf[k] = 1'b0;
        end
      end
      if (vs && !m_vs_prev) m_frame = m_frame + 16'd1;
      m_vs_prev  = vs;
      m_sel_prev = m_sel;
    end
  end

  function automatic logic [7:0] exp_byte(int k, logic [24:0] a);
    int aw, n, idx;
    logic [15:0] dep, n16;
    logic [63:0] r;
    aw  = (k == 0) ? 10 : 2;
    n   = log_size(k);
    n16 = 16'(n);
    dep = 16'(log_depth(k));
    if (((a >> (aw + 3)) != 25'd0) || (int'(a) >= 8 + 8 * n)) return 8'hFF;
    if (a < 25'd8) begin
      case (int'(a))
        0: return n16[7:0];
        1: return n16[15:8];
        2: return {6'b0, ANALOG, m_ovf[k]};
        4: return dep[7:0];
        5: return dep[15:8];
        default: return 8'h00;
      endcase
    end
    idx = (int'(a) - 8) / 8;
    r = (k == 0) ? exp_q0[idx] : exp_q1[idx];
    return r[8 * int'(a[2:0]) +: 8];
  endfunction

  // Driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [24:0] a, output logic [7:0] db, output logic [7:0] ds,
                         output int wb, output int ws);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    wb = 0; ws = 0;
    for (int i = 0; i < 5; i++) begin
      if (ioctl_wait) wb++;
      if (wait_s) ws++;
      tick();
    end
    db = ioctl_din;
    ds = din_s;
  endtask

  task automatic read_check(input logic [24:0] a, output logic [7:0] db, output logic [7:0] ds);
    int wb, ws;
    do_read(a, db, ds, wb, ws);
    chk($sformatf("wait_cycles_big@%0h", a), wb, 2);
    chk($sformatf("wait_cycles_small@%0h", a), ws, 2);
    chk($sformatf("din_big@%0h", a), db, exp_byte(0, a));
    chk($sformatf("din_small@%0h", a), ds, exp_byte(1, a));
  endtask

  initial begin
    logic [7:0] db, ds;
    logic [7:0] lit [8];
    int n, w, base;
    logic [24:0] a;

    // Reset
    tick(3);
    reset_n = 1'b1;
    tick();
    chk("reset_count", 32'(count), 0);
    chk("reset_count_small", 32'(count_s), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_din", 32'(ioctl_din), 0);
    chk("reset_wait", 32'(ioctl_wait), 0);

    // Empty-log header
    ioctl_index = 8'd2; ioctl_upload = 1'b1; tick();
    for (int i = 0; i < 9; i++) begin
      read_check(25'(i), db, ds);
      if (i == 5) chk("depth_hi_lit", 32'(db), 32'h04);
      if (i == 8) chk("empty_rec_lit", 32'(db), 32'hFF);
    end
    ioctl_upload = 1'b0; tick(2);

    // Three frames then one change
    repeat (3) begin vs = 1'b1; tick(); vs = 1'b0; tick(); end
    joystick_0 = 32'h0000_0010; tick(2);
    ioctl_upload = 1'b1; tick();
    chk("one_rec_count", 32'(count), 1);
    lit = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      read_check(25'(8 + i), db, ds);
      chk($sformatf("one_rec_lit%0d", i), 32'(db), 32'(lit[i]));
    end
    ioctl_upload = 1'b0; tick(2);

    // Random capture
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) joystick_0 = $urandom();
      if ($urandom_range(0, 3) == 0) joystick_analog_0 = 16'($urandom());
      vs = 1'($urandom_range(0, 1));
      tick();
    end
    vs = 1'b0; tick();
    chk("rand_count", 32'(count), log_size(0));
    chk("rand_count_small", 32'(count_s), log_size(1));
    chk("rand_ovf", 32'(overflow), 32'(m_ovf[0]));
    chk("rand_ovf_small", 32'(ovf_s), 32'(m_ovf[1]));
    chk("small_full_lit", 32'(count_s), 4);

    // Upload: capture frozen, header and records
    ioctl_upload = 1'b1; tick();
    n = log_size(0);
    repeat (4) begin joystick_0 = $urandom(); tick(); end
    chk("frozen_count", 32'(count), 32'(n));
    chk("frozen_count_small", 32'(count_s), 4);
    for (int i = 0; i < 8; i++) begin
      read_check(25'(i), db, ds);
      if (i == 2) chk("small_flags_lit", 32'(ds), 32'({6'b0, ANALOG, 1'b1}));
    end
    if (n > 0) begin
      repeat (6) begin
        a = 25'($urandom_range(8, 8 + 8 * n - 1));
        read_check(a, db, ds);
      end
    end
    read_check(25'(39), db, ds);
    read_check(25'(40), db, ds);
    read_check(25'(8 + 8 * n), db, ds);
    read_check(25'h2008, db, ds);
    joystick_0 = 32'h0; joystick_analog_0 = 16'h0; tick();
    ioctl_upload = 1'b0; tick(2);
    chk("cleared_count", 32'(count), 0);
    chk("cleared_count_small", 32'(count_s), 0);
    chk("cleared_ovf", 32'(overflow), 0);
    chk("cleared_ovf_small", 32'(ovf_s), 0);

    // Other index: capture continues, reads ignored
    ioctl_index = 8'd1; ioctl_upload = 1'b1;
    joystick_0 = 32'h0000_00A5; tick(2);
    chk("idx1_count", 32'(count), 1);
    chk("idx1_count_model", 32'(count), log_size(0));
    ioctl_addr = 25'd0; ioctl_rd = 1'b1; tick(); ioctl_rd = 1'b0;
    w = 0;
    repeat (4) begin if (ioctl_wait || wait_s) w++; tick(); end
    chk("idx1_wait", 32'(w), 0);
    chk("idx1_din_held", 32'(ioctl_din), 32'hFF);
    ioctl_upload = 1'b0; ioctl_index = 8'd2; tick();

    // Upload ends mid-read
    ioctl_upload = 1'b1; tick();
    ioctl_addr = 25'd0; ioctl_rd = 1'b1; tick(); ioctl_rd = 1'b0;
    chk("abort_wait_hi", 32'(ioctl_wait), 1);
    ioctl_upload = 1'b0; tick();
    chk("abort_wait_lo", 32'(ioctl_wait), 0);
    chk("abort_wait_lo_small", 32'(wait_s), 0);
    tick(2);

    // Reset mid-read
    ioctl_upload = 1'b1; tick();
    chk("pre_reset_count", 32'(count), log_size(0));
    ioctl_addr = 25'd0; ioctl_rd = 1'b1; tick(); ioctl_rd = 1'b0;
    chk("pre_reset_wait", 32'(ioctl_wait), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_din", 32'(ioctl_din), 0);
    chk("rst_count", 32'(count), 0);
    tick();
    reset_n = 1'b1; tick();
    for (int i = 0; i < 8; i++) read_check(25'(i), db, ds);
    ioctl_upload = 1'b0; tick(2);

`ifdef INPUT_LOG_ANALOG_EN
    // Analog-only change
    joystick_analog_0 = 16'h12F0; tick(2);
    ioctl_upload = 1'b1; tick();
    n = log_size(0);
    base = 8 + 8 * (n - 1);
    for (int i = 0; i < 8; i++) begin
      read_check(25'(base + i), db, ds);
      if (i == 6) chk("analog_lo_lit", 32'(db), 32'hF0);
      if (i == 7) chk("analog_hi_lit", 32'(db), 32'h12);
    end
    read_check(25'd2, db, ds);
    chk("analog_flags_lit", 32'(db), 32'h02);
    ioctl_upload = 1'b0; tick(2);
`endif

    // Report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
